// File: rtl/out_mem_rd_ctrl.sv
// Read-back engine for the output bank array: walks every result address once,
// returns one SYS_COL-wide row per beat to the host behind a 2-entry buffer.
module out_mem_rd_ctrl #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          num_in,
  input  logic [DATA_WIDTH-1:0]          num_out,
  output logic [SYS_COL-1:0]             rd_en,
  output logic [ADDR_WIDTH*SYS_COL-1:0]  rd_addr,
  input  logic [PSUM_WIDTH*SYS_COL-1:0]  rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PSUM_WIDTH*SYS_COL-1:0]  out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     state_dbg
);

  localparam int LANE_SHIFT = $clog2(SYS_COL);
  localparam int ROW_W      = PSUM_WIDTH * SYS_COL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] rows_q, cols_q, row_q, col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] cols_in;
  logic                  total_zero, start_ok, last_rd, issue, pop, push, drained;
  logic [2:0]            occ;
  logic                  inflight_q, inflight_last_q, zero_done_q;
  logic [ROW_W-1:0]      fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  assign cols_in    = num_out >> LANE_SHIFT;
  assign total_zero = (num_in == '0) || (cols_in == '0);
  assign start_ok   = start && (state_q == S_IDLE);
  assign last_rd    = (row_q == rows_q - DATA_WIDTH'(1)) && (col_q == cols_q - DATA_WIDTH'(1));
  assign push       = inflight_q;
  assign drained    = (count_q == 2'd0) && !inflight_q;

  // Host stream: a beat transfers on any cycle where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_valid/out_data/out_last hold steady.
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Credit: buffered + in-flight entries, minus the one leaving now, must leave room.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !total_zero) state_d = S_RUN;
      S_RUN:   if (issue && last_rd)     state_d = S_DRAIN;
      S_DRAIN: if (drained)              state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = ((state_q == S_DRAIN) && drained) || zero_done_q;
    rd_en     = {SYS_COL{issue}};
    rd_addr   = {SYS_COL{addr_q}};
    out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last  = out_valid && fifo_last_q[rd_ptr_q];
    state_dbg = state_q;
  end

  // Row/col counters bound the walk so no multiplier is needed for TOTAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q          <= '0;
      cols_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      zero_done_q     <= start_ok && total_zero;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_rd;
      if (start_ok) begin
        rows_q <= num_in;
        cols_q <= cols_in;
        row_q  <= '0;
        col_q  <= '0;
        addr_q <= '0;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (col_q == cols_q - DATA_WIDTH'(1)) begin
          col_q <= '0;
          row_q <= row_q + DATA_WIDTH'(1);
        end else begin
          col_q <= col_q + DATA_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_out_mem_rd_ctrl.sv
// Bench for out_mem_rd_ctrl: bank memory model, randomized host back-pressure,
// expected-beat queue built from the row/column arithmetic of each transfer.
module tb_out_mem_rd_ctrl;

  localparam int SYS_COL = 16;
  localparam int DATA_WIDTH = 16;
  localparam int AW = 16;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int DW = PW * SYS_COL;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [DATA_WIDTH-1:0] num_in, num_out;
  logic [SYS_COL-1:0]    rd_en;
  logic [AW*SYS_COL-1:0] rd_addr;
  logic [DW-1:0]         rd_data;
  logic                  out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0]         out_data;
  logic [1:0]            state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW:0] exp_q[$];
  int  s_cyc, rd_cnt, beats, done_cnt, done_cyc, last_hs_cyc, first_valid_rel, outstanding;
  bit  track = 1'b0;
  bit  done_past, xfer_nonzero, prev_stall;
  logic [DW-1:0] prev_data;

  out_mem_rd_ctrl #(.SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_in(num_in), .num_out(num_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bank memory: word = addr*16 + bank, garbage when a bank is not read
  always @(posedge clk) begin
    for (int k = 0; k < SYS_COL; k++) begin
      if (rd_en[k]) rd_data[k*PW +: PW] <= PW'(rd_addr[k*AW +: AW]) * PW'(SYS_COL) + PW'(k);
      else          rd_data[k*PW +: PW] <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [DW:0] e;
    bit pop_now;
    bit exp_busy;
    if (track && !rst) begin
      pop_now = out_valid && out_ready;
      if (rd_en != '0) begin
        check("rd_en_uniform", DW'(rd_en == '1), 1);
        check("rd_addr", rd_addr, {SYS_COL{AW'(rd_cnt)}});
        check("credit", DW'((outstanding - int'(pop_now)) < 2), 1);
        rd_cnt++;
      end
      outstanding = outstanding + int'(rd_en[0]) - int'(pop_now);
      if (out_valid && first_valid_rel < 0) first_valid_rel = cyc - s_cyc;
      if (prev_stall) begin
        check("hold_valid", DW'(out_valid), 1);
        check("hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (pop_now) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat", {out_last, out_data}, e);
        end
        if (out_last) last_hs_cyc = cyc;
      end
      exp_busy = xfer_nonzero && (cyc > s_cyc) && !done_past;
      check("busy", DW'(busy), DW'(exp_busy));
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_past = 1'b1;
      end
    end
  end

  function automatic logic ready_for(input int mode, input int rel);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return rel >= 10;
    return 1'b1;
  endfunction

  // driver: mode 0 ready always, 1 random ready, 2 ready from relative cycle 10
  task automatic run_xfer(input int m, input int n, input int mode, input int restart_at);
    int total, rel, budget;
    logic [DW-1:0] row;
    total = m * (n / SYS_COL);
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      for (int k = 0; k < SYS_COL; k++) row[k*PW +: PW] = PW'(i * SYS_COL + k);
      exp_q.push_back({(i == total - 1), row});
    end
    rd_cnt = 0; beats = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    first_valid_rel = -1; outstanding = 0; done_past = 1'b0; prev_stall = 1'b0;
    xfer_nonzero = (total != 0);
    @(posedge clk); #1;
    num_in = DATA_WIDTH'(m); num_out = DATA_WIDTH'(n); start = 1'b1;
    s_cyc = cyc; out_ready = ready_for(mode, 0); track = 1'b1;
    budget = 0;
    while (!done_past && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      rel = cyc - s_cyc;
      start = (rel == restart_at);
      num_in = DATA_WIDTH'($urandom_range(0, 9));
      num_out = DATA_WIDTH'(16 * $urandom_range(0, 4));
      out_ready = ready_for(mode, rel);
    end
    check("done_seen", DW'(done_past), 1);
    repeat (3) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      start = 1'b0;
    end
    track = 1'b0;
    check("beat_count", DW'(beats), DW'(total));
    check("exp_empty", DW'(exp_q.size()), 0);
    check("done_count", DW'(done_cnt), 1);
    check("read_count", DW'(rd_cnt), DW'(total));
    if (total == 0) begin
      check("zero_done_rel", DW'(done_cyc - s_cyc), 1);
      check("zero_first_valid", DW'(first_valid_rel), DW'(-1));
    end else begin
      check("done_after_last", DW'(done_cyc - last_hs_cyc), 1);
      check("first_valid_rel", DW'(first_valid_rel), 3);
      if (mode == 0) check("done_rel", DW'(done_cyc - s_cyc), DW'(total + 3));
      if (mode == 2) check("done_rel_stall", DW'(done_cyc - s_cyc), 11);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_en"}, DW'(rd_en), 0);
    check({pfx, "_rd_addr"}, DW'(rd_addr), 0);
    check({pfx, "_out_valid"}, DW'(out_valid), 0);
    check({pfx, "_out_data"}, DW'(out_data), 0);
    check({pfx, "_out_last"}, DW'(out_last), 0);
    check({pfx, "_busy"}, DW'(busy), 0);
    check({pfx, "_done"}, DW'(done), 0);
  endtask

  initial begin
    int hs, b;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; num_in = '0; num_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_xfer(4, 32, 0, -1);
    run_xfer(4, 32, 1, -1);
    run_xfer(0, 8, 0, -1);
    run_xfer(3, 8, 0, -1);
    run_xfer(8, 32, 0, 5);

    // abort mid-transfer with the host stalled
    @(posedge clk); #1;
    num_in = 16'd4; num_out = 16'd64; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; b = 0;
    while (hs < 3 && b < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      b++;
    end
    check("pre_abort_beats", DW'(hs), 3);
    @(posedge clk); #1;
    out_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", DW'(done), 0);
    run_xfer(4, 64, 0, -1);

    run_xfer(1, 16, 2, -1);
    for (int t = 0; t < 6; t++) run_xfer($urandom_range(1, 5), 16 * $urandom_range(1, 4), 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
